viterbi_dec: RTL

- Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7/5 octal) produced by the lab 8 encoder.
- Accepts one 2-bit coded symbol per valid cycle and recovers the original info bit stream after a fixed decision depth.
- Uses register-exchange survivor memory with per-cycle path-metric normalisation.
- Sits at the receive end of the lab 8 encode/decode loopback.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/viterbi_dec_if.sv | 11 +
 rtl/viterbi_dec_acs.sv | 22 ++
 rtl/viterbi_dec.sv | 107 ++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Code definition shared by encoder-side models and the Viterbi decoder (K=3, 7/5 octal).
// Pure constants and combinational helpers; no latency, no flow control.
package conv_pkg;
    localparam int            K          = 3;
    localparam int            NUM_STATES = 4;
    localparam logic [K-1:0]  G0         = 3'b111;
    localparam logic [K-1:0]  G1         = 3'b101;

    // State is {b[n-1], b[n-2]}
    typedef logic [1:0] state_t;

    function automatic logic [1:0] exp_sym(input state_t prev, input logic b);
        logic [K-1:0] taps;
        taps = {b, prev};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction
endpackage

// File: rtl/viterbi_dec_if.sv
// Coded-symbol input and decoded-bit output of the Viterbi decoder.
// Valid-only strobes both ways; the decoder never stalls its source.
interface viterbi_dec_if;
    logic       coded_valid;
    logic [1:0] coded;
    logic       info_valid;
    logic       info;

    modport master (output coded_valid, coded, input info_valid, info);
    modport slave  (input coded_valid, coded, output info_valid, info);
endinterface

// File: rtl/viterbi_dec_acs.sv
// Add-compare-select for one trellis state plus its register-exchange survivor update.
// Purely combinational; ties resolve to candidate 0 (predecessor {x,0}).
module viterbi_acs #(
    parameter int PM_W     = 5,
    parameter int TB_DEPTH = 15
) (
    input  logic [PM_W:0]     cand0_i,
    input  logic [PM_W:0]     cand1_i,
    input  logic [TB_DEPTH-1:0] surv0_i,
    input  logic [TB_DEPTH-1:0] surv1_i,
    input  logic              b_i,
    output logic [PM_W:0]     pm_o,
    output logic [TB_DEPTH-1:0] surv_o
);
    logic                pick1;
    logic [TB_DEPTH-1:0] chosen;

    assign pick1  = cand1_i < cand0_i;
    assign pm_o   = pick1 ? cand1_i : cand0_i;
    assign chosen = pick1 ? surv1_i : surv0_i;
    assign surv_o = (chosen << 1) | TB_DEPTH'(b_i);
endmodule

// File: rtl/viterbi_dec.sv
// Hard-decision Viterbi decoder, rate 1/2 K=3; bit j emerges one cycle after symbol j+TB_DEPTH-1 is accepted.
// No backpressure: every coded_valid symbol is consumed; idle cycles only stretch latency.
module viterbi_dec
    import conv_pkg::*;
#(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 5,
    parameter int INIT_PM  = 8
) (
    input  logic         clk,
    input  logic         srst,
    viterbi_dec_if.slave bus
);
    localparam int                CNT_W    = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TB_DEPTH - 1);
    localparam logic [PM_W:0]     PM_SAT   = {1'b0, {PM_W{1'b1}}};

    logic [PM_W-1:0]     pm_q   [NUM_STATES];
    logic [PM_W-1:0]     pm_d   [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_q [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_d [NUM_STATES];
    logic [PM_W:0]       acs_pm [NUM_STATES];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                info_q, info_d;
    logic                info_vld_q, info_vld_d;
    logic [PM_W:0]       min_pm;
    logic [PM_W:0]       diff;
    state_t              best;
    logic                found;

    // Next state {b,x} is reached from {x,0} and {x,1} with input bit b
    for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
        localparam state_t P0 = state_t'((ns % 2) * 2);
        localparam state_t P1 = state_t'((ns % 2) * 2 + 1);
        localparam logic   B  = (ns / 2) != 0;

        logic [PM_W:0] cand0, cand1;

        assign cand0 = (PM_W+1)'(pm_q[P0]) + (PM_W+1)'(hamming2(bus.coded, exp_sym(P0, B)));
        assign cand1 = (PM_W+1)'(pm_q[P1]) + (PM_W+1)'(hamming2(bus.coded, exp_sym(P1, B)));

        viterbi_acs #(
            .PM_W     (PM_W),
            .TB_DEPTH (TB_DEPTH)
        ) u_acs (
            .cand0_i (cand0),
            .cand1_i (cand1),
            .surv0_i (surv_q[P0]),
            .surv1_i (surv_q[P1]),
            .b_i     (B),
            .pm_o    (acs_pm[ns]),
            .surv_o  (surv_d[ns])
        );
    end

    always_comb begin
        min_pm = acs_pm[0];
        diff   = '0;
        for (int s = 1; s < NUM_STATES; s++) begin
            if (acs_pm[s] < min_pm) min_pm = acs_pm[s];
        end
        for (int s = 0; s < NUM_STATES; s++) begin
            diff     = acs_pm[s] - min_pm;
            pm_d[s]  = (diff > PM_SAT) ? PM_SAT[PM_W-1:0] : diff[PM_W-1:0];
        end
        // Lowest-index state holding the zero (minimum) normalised metric
        best  = '0;
        found = 1'b0;
        for (int s = 0; s < NUM_STATES; s++) begin
            if (!found && pm_d[s] == '0) begin
                best  = state_t'(s);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d      = (cnt_q >= CNT_LAST) ? CNT_LAST : cnt_q + 1'b1;
        info_d     = surv_d[best][TB_DEPTH-1];
        info_vld_d = cnt_q >= CNT_LAST;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : PM_W'(INIT_PM);
                surv_q[s] <= '0;
            end
            cnt_q      <= '0;
            info_q     <= 1'b0;
            info_vld_q <= 1'b0;
        end else if (bus.coded_valid) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                pm_q[s]   <= pm_d[s];
                surv_q[s] <= surv_d[s];
            end
            cnt_q      <= cnt_d;
            info_q     <= info_d;
            info_vld_q <= info_vld_d;
        end else begin
            info_vld_q <= 1'b0;
        end
    end

    assign bus.info       = info_q;
    assign bus.info_valid = info_vld_q;
endmodule
